// File: rtl/eval_board_loader_if.sv
// rtl/eval_board_loader_if.sv - square stream, board-memory, evaluator and result signals of the board loader
interface eval_board_loader_if;
    logic        sq_valid_in;
    logic        sq_ready_out;
    logic [5:0]  sq_idx_in;
    logic [3:0]  sq_piece_in;
    logic        sq_last_in;
    logic        side_in;
    logic        clear_in;
    logic [31:0] mem_data_out;
    logic        mem_wr_out;
    logic [2:0]  mem_wr_addr_out;
    logic        start_out;
    logic        side_out;
    logic        finished_in;
    logic [14:0] result_in;
    logic        res_valid_out;
    logic [14:0] res_data_out;
    logic        res_ready_in;

    // Environment side: feeds squares, plays the evaluator and consumes the score
    modport master (
        output sq_valid_in, sq_idx_in, sq_piece_in, sq_last_in, side_in, clear_in,
        output finished_in, result_in, res_ready_in,
        input  sq_ready_out, mem_data_out, mem_wr_out, mem_wr_addr_out,
        input  start_out, side_out, res_valid_out, res_data_out
    );

    // Loader side
    modport slave (
        input  sq_valid_in, sq_idx_in, sq_piece_in, sq_last_in, side_in, clear_in,
        input  finished_in, result_in, res_ready_in,
        output sq_ready_out, mem_data_out, mem_wr_out, mem_wr_addr_out,
        output start_out, side_out, res_valid_out, res_data_out
    );
endinterface

// File: rtl/eval_board_loader.sv
// rtl/eval_board_loader.sv - shadow chess board, flush to evaluator memory, start and score return
module eval_board_loader (
    input  logic                 clk,
    input  logic                 rst,
    eval_board_loader_if.slave   bus
);
    localparam logic [2:0] ST_LOAD   = 3'd0;
    localparam logic [2:0] ST_FLUSH  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;

    // Square n lives in nibble n, so board word k is simply bits [32k+31:32k]
    logic [2:0]   state_q,     state_d;
    logic [255:0] board_q,     board_d;
    logic [2:0]   word_k_q,    word_k_d;
    logic         side_q,      side_d;
    logic         mem_wr_q,    mem_wr_d;
    logic [2:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]  mem_data_q,  mem_data_d;
    logic         start_q,     start_d;
    logic         res_valid_q, res_valid_d;
    logic [14:0]  res_data_q,  res_data_d;

    logic beat;
    assign beat = (state_q == ST_LOAD) && bus.sq_valid_in;

    // Next-state logic: board updates in LOAD, word sequencing in FLUSH, evaluator handshake after
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        word_k_d    = word_k_q;
        side_d      = side_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = 3'd0;
        mem_data_d  = 32'd0;
        start_d     = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.clear_in) begin
                    board_d = '0;
                end
                if (beat) begin
                    board_d[{bus.sq_idx_in, 2'b00} +: 4] = bus.sq_piece_in;
                    if (bus.sq_last_in) begin
                        // Word 0 goes out on the very next cycle, including this beat's square
                        side_d     = bus.side_in;
                        word_k_d   = 3'd0;
                        mem_wr_d   = 1'b1;
                        mem_addr_d = 3'd0;
                        mem_data_d = board_d[31:0];
                        state_d    = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (word_k_q == 3'd7) begin
                    start_d = 1'b1;
                    state_d = ST_START;
                end else begin
                    word_k_d   = word_k_q + 3'd1;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = word_k_d;
                    mem_data_d = board_q[{word_k_d, 5'b00000} +: 32];
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.finished_in) begin
                    res_data_d  = bus.result_in;
                    res_valid_d = 1'b1;
                    state_d     = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (bus.res_ready_in) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State registers; reset abandons any flush in progress and empties the board
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            board_q     <= '0;
            word_k_q    <= 3'd0;
            side_q      <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 3'd0;
            mem_data_q  <= 32'd0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 15'd0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            word_k_q    <= word_k_d;
            side_q      <= side_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.sq_ready_out    = (state_q == ST_LOAD);
    assign bus.mem_data_out    = mem_data_q;
    assign bus.mem_wr_out      = mem_wr_q;
    assign bus.mem_wr_addr_out = mem_addr_q;
    assign bus.start_out       = start_q;
    assign bus.side_out        = side_q;
    assign bus.res_valid_out   = res_valid_q;
    assign bus.res_data_out    = res_data_q;
endmodule

// File: tb/tb_eval_board_loader.sv
// tb/tb_eval_board_loader.sv - randomized self-checking bench for eval_board_loader
module tb_eval_board_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eval_board_loader_if bus();

    eval_board_loader u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference board: one piece code per square, plus the latched side to move
    int   model_sq [64];
    logic model_side;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 8; j++) begin
            w = w | (32'(model_sq[8*k + j]) << (4*j));
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sq_valid_in  = 1'b0;
        bus.sq_idx_in    = 6'd0;
        bus.sq_piece_in  = 4'd0;
        bus.sq_last_in   = 1'b0;
        bus.side_in      = 1'b0;
        bus.clear_in     = 1'b0;
        bus.finished_in  = 1'b0;
        bus.result_in    = 15'd0;
        bus.res_ready_in = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_sq[i] = 0;
        model_side = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"},  32'(bus.sq_ready_out),    32'd1);
        check({tag, ".wr"},     32'(bus.mem_wr_out),      32'd0);
        check({tag, ".addr"},   32'(bus.mem_wr_addr_out), 32'd0);
        check({tag, ".data"},   bus.mem_data_out,         32'd0);
        check({tag, ".start"},  32'(bus.start_out),       32'd0);
        check({tag, ".side"},   32'(bus.side_out),        32'd0);
        check({tag, ".rvalid"}, 32'(bus.res_valid_out),   32'd0);
        check({tag, ".rdata"},  32'(bus.res_data_out),    32'd0);
    endtask

    // One beat presented for one cycle while in LOAD; always accepted there
    task automatic beat(input int idx, input int piece, input logic last, input logic side, input logic clr);
        bus.sq_valid_in = 1'b1;
        bus.sq_idx_in   = 6'(idx);
        bus.sq_piece_in = 4'(piece);
        bus.sq_last_in  = last;
        bus.side_in     = side;
        bus.clear_in    = clr;
        if (clr) for (int i = 0; i < 64; i++) model_sq[i] = 0;
        model_sq[idx] = piece;
        if (last) model_side = side;
        tick();
        bus.sq_valid_in = 1'b0;
        bus.sq_last_in  = 1'b0;
        bus.clear_in    = 1'b0;
        bus.side_in     = ~side;
    endtask

    // Called in cycle T+1 after the last beat; walks flush, start, wait and result handshake
    task automatic run_flush(input int fin_delay, input logic [14:0] res, input int ready_delay, input logic inject);
        for (int k = 0; k < 8; k++) begin
            check("flush.wr",    32'(bus.mem_wr_out),      32'd1);
            check("flush.addr",  32'(bus.mem_wr_addr_out), 32'(k));
            check("flush.data",  bus.mem_data_out,         exp_word(k));
            check("flush.ready", 32'(bus.sq_ready_out),    32'd0);
            check("flush.start", 32'(bus.start_out),       32'd0);
            if (inject) begin
                bus.finished_in = 1'b1;
                bus.clear_in    = 1'b1;
                bus.result_in   = ~res;
            end
            tick();
        end
        check("start.pulse", 32'(bus.start_out),    32'd1);
        check("start.wr",    32'(bus.mem_wr_out),   32'd0);
        check("start.side",  32'(bus.side_out),     32'(model_side));
        check("start.ready", 32'(bus.sq_ready_out), 32'd0);
        tick();
        bus.finished_in = 1'b0;
        bus.clear_in    = 1'b0;
        check("wait.start",  32'(bus.start_out),     32'd0);
        check("wait.rvalid", 32'(bus.res_valid_out), 32'd0);
        for (int i = 0; i < fin_delay; i++) begin
            tick();
            check("wait.rvalid", 32'(bus.res_valid_out), 32'd0);
            check("wait.start",  32'(bus.start_out),     32'd0);
        end
        bus.finished_in = 1'b1;
        bus.result_in   = res;
        tick();
        bus.finished_in = 1'b0;
        bus.result_in   = 15'($urandom);
        check("res.valid", 32'(bus.res_valid_out), 32'd1);
        check("res.data",  32'(bus.res_data_out),  32'(res));
        check("res.ready", 32'(bus.sq_ready_out),  32'd0);
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            check("res.hold_valid", 32'(bus.res_valid_out), 32'd1);
            check("res.hold_data",  32'(bus.res_data_out),  32'(res));
        end
        bus.res_ready_in = 1'b1;
        tick();
        bus.res_ready_in = 1'b0;
        check("done.valid", 32'(bus.res_valid_out), 32'd0);
        check("done.ready", 32'(bus.sq_ready_out),  32'd1);
        check("done.side",  32'(bus.side_out),      32'(model_side));
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Empty board: single last beat writing a zero square
        beat(0, 0, 1'b1, 1'b0, 1'b0);
        run_flush(0, 15'h0123, 0, 1'b0);

        // Packing, with the result held back for five cycles
        beat(0, 4'h6, 1'b0, 1'b0, 1'b0);
        beat(7, 4'hC, 1'b0, 1'b0, 1'b0);
        beat(9, 4'h1, 1'b0, 1'b0, 1'b0);
        beat(63, 4'hE, 1'b1, 1'b1, 1'b0);
        run_flush(5, 15'h7F83, 5, 1'b0);

        // Delta position, then clear combined with the last beat
        beat(9, 4'h3, 1'b1, 1'b0, 1'b0);
        run_flush(1, 15'h0042, 1, 1'b0);
        beat(4, 4'h5, 1'b1, 1'b1, 1'b1);
        run_flush(2, 15'h4000, 0, 1'b0);

        // Duplicate index, with stray finished/clear during flush and start
        beat(2, 4'h1, 1'b0, 1'b0, 1'b0);
        beat(2, 4'h9, 1'b0, 1'b0, 1'b0);
        beat(40, 4'h7, 1'b1, 1'b0, 1'b0);
        run_flush(3, 15'h1555, 2, 1'b1);

        // Reset in the middle of a flush
        beat(17, 4'hB, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_reset_outputs("midrst");
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst.nostart", 32'(bus.start_out),  32'd0);
            check("midrst.nowr",    32'(bus.mem_wr_out), 32'd0);
        end
        beat(5, 4'hA, 1'b1, 1'b0, 1'b0);
        run_flush(0, 15'h2AAA, 0, 1'b0);

        // Random positions
        for (int p = 0; p < 24; p++) begin
            int nb;
            nb = $urandom_range(0, 9);
            for (int b = 0; b < nb; b++) begin
                beat($urandom_range(0, 63), $urandom_range(0, 15), 1'b0, 1'($urandom),
                     ($urandom_range(0, 9) == 0));
            end
            beat($urandom_range(0, 63), $urandom_range(0, 15), 1'b1, 1'($urandom),
                 ($urandom_range(0, 7) == 0));
            run_flush($urandom_range(0, 4), 15'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eval_board_loader.md
# eval_board_loader

Upstream feeder for the chess evaluation core. Accepts a stream of square/piece writes and keeps a 64-square shadow board of 4-bit piece codes. On the last beat it packs the board into eight 32-bit words and writes them to the evaluator's board memory. It then pulses the evaluator's start with the side to move, waits for `finished`, and returns the 15-bit score on a valid/ready result port.

## Interface
- No parameters; widths fixed: 64 squares, 4-bit piece code, 8 × 32-bit board words, 15-bit result.
- `clk` in 1 — single clock, all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `sq_valid_in` in 1 — square beat valid.
- `sq_ready_out` out 1 — loader accepts a beat; beat transfers when valid && ready.
- `sq_idx_in` in 6 — square index 0..63.
- `sq_piece_in` in 4 — piece code; 0 = empty.
- `sq_last_in` in 1 — final beat of a position; triggers flush.
- `side_in` in 1 — side to move; sampled with the last beat.
- `clear_in` in 1 — zero the shadow board; honoured only in LOAD.
- `mem_data_out` out 32 — board word to evaluator memory.
- `mem_wr_out` out 1 — board-memory write strobe.
- `mem_wr_addr_out` out 3 — board word address.
- `start_out` out 1 — one-cycle start pulse to evaluator.
- `side_out` out 1 — side to move presented to evaluator.
- `finished_in` in 1 — evaluator done.
- `result_in` in 15 — evaluator score, two's complement.
- `res_valid_out` out 1 — score available.
- `res_data_out` out 15 — captured score.
- `res_ready_in` in 1 — consumer accepts score.

## Operation
- **States:** LOAD, FLUSH, START, WAIT, RESULT. Reset state is LOAD.
- **LOAD:**
  - `sq_ready_out`=1.
  - An accepted beat writes `sq_piece_in` to board[`sq_idx_in`]. Duplicate indices: last write wins.
  - `clear_in` zeroes all squares in the same cycle. If a beat is also accepted that cycle, its square takes the beat's piece (write beats clear).
  - An accepted beat with `sq_last_in`=1 writes its square, latches `side_in` into `side_out`, clears the word counter, and moves to FLUSH.
- **FLUSH:**
  - `sq_ready_out`=0.
  - One word per cycle, counter k = 0..7: `mem_wr_out`=1, `mem_wr_addr_out`=k.
  - `mem_data_out`[4j+3:4j] = board[8k+j] for j = 0..7.
  - After k=7, go to START. The counter stops at 7 and never wraps.
- **START:** `start_out`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** when `finished_in`=1, capture `result_in` into `res_data_out` and go to RESULT.
- **RESULT:**
  - `res_valid_out`=1; `res_data_out` held stable.
  - When `res_ready_in`=1, return to LOAD. The board is retained so the next position can be sent as a delta.
- `finished_in` is ignored in every state other than WAIT.
- `clear_in` is ignored outside LOAD.
- `side_out` holds its latched value until the next last beat.
- **Reset (any state, including mid-FLUSH or WAIT):**
  - Board zeroed; state LOAD.
  - All outputs return to their reset values.
  - Any partial memory write sequence is abandoned.
- **Reset values:** `sq_ready_out`=1 in LOAD after reset. All other outputs are 0: `mem_*`, `start_out`, `side_out`, `res_valid_out`, `res_data_out`.

## Timing
- Last beat accepted at cycle T:
  - `mem_wr_out` is high in cycles T+1..T+8, with addresses 0..7 in order.
  - `start_out` is high in cycle T+9 only.
  - `sq_ready_out` is low from T+1 until the cycle after result acceptance.
- `finished_in` sampled high at cycle F (F ≥ T+10) → `res_valid_out` high from F+1.
- `res_ready_in` high at cycle R while `res_valid_out`=1 → `res_valid_out` is 0 and `sq_ready_out` is 1 at R+1.
- Minimum position-to-result latency is 11 cycles from the last beat to `res_valid_out`, given `finished_in` at T+10.
- The last beat is accepted in LOAD only. A position therefore needs at least one beat, the last one.
- Board-memory outputs are registered: the address, data and strobe change together.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0 except `sq_ready_out`=1; a flush with only beat (idx 0, piece 0, last) writes eight zero words to addresses 0..7.
- **Packing:** write idx 0 = 0x6, idx 7 = 0xC, idx 9 = 0x1, idx 63 = 0xE (last, side 1):
  - addr 0 word = 0xC0000006; addr 1 = 0x00000010; addr 7 = 0xE0000000.
  - `start_out` pulses at T+9; `side_out`=1.
- **Result handshake:** `finished_in` at T+15 with `result_in` = 15'h7F83 (−125); hold `res_ready_in`=0 for 5 cycles → `res_data_out` stable at 0x7F83. Then ready → back to LOAD next cycle.
- **Delta and clear:**
  - Second position sending only idx 9 = 0x3 (last) → addr 1 = 0x00000030; other words are unchanged from the packing test.
  - `clear_in` together with beat idx 4 = 0x5 (last) → addr 0 = 0x00050000; all other words 0.
- **Ignored and duplicate inputs:**
  - `finished_in` pulsed during FLUSH and START is ignored; the result is captured only on the later WAIT pulse.
  - Duplicate writes to idx 2 of 0x1 then 0x9 → the nibble carries 0x9.
- **Reset mid-operation:** assert `rst` at T+4 (mid-FLUSH) → `mem_wr_out` is 0 next cycle, no `start_out` pulse follows, and the next position flushes from address 0.
